// File: rtl/multicycle_processor.sv
// Multicycle ARM-subset core: one shared memory port, one ALU, and a main control FSM
// stepping each instruction through FETCH/DECODE/execute/writeback states.
module multicycle_processor #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ENABLE_BL = 1,
  parameter int          STATE_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        MemRD,
  output logic [31:0]        MemAdr,
  output logic [31:0]        MemWD,
  output logic               MemWE,
  output logic               InstrDone,
  output logic [STATE_W-1:0] DBstate,
  input  logic [3:0]         DBtheReg,
  output logic [31:0]        DBtheRegVal
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_ORR = 2'd3;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, ir_reg, a_reg, wd_reg, aluout_reg, data_reg;
  logic [3:0]  nzcv_reg;

  // Instruction fields
  logic [3:0] cond, cmd, rn, rd, rm;
  logic [1:0] op;
  logic       ibit, sbit, ubit, lbit, link;
  assign cond = ir_reg[31:28];
  assign op   = ir_reg[27:26];
  assign ibit = ir_reg[25];
  assign cmd  = ir_reg[24:21];
  assign link = ir_reg[24];
  assign ubit = ir_reg[23];
  assign sbit = ir_reg[20];
  assign lbit = ir_reg[20];
  assign rn   = ir_reg[19:16];
  assign rd   = ir_reg[15:12];
  assign rm   = ir_reg[3:0];

  logic [31:0] pc_plus4;
  assign pc_plus4 = pc_reg + 32'd4;

  // Register file R0..R14; R15 reads are synthesised from the PC
  logic [31:0] rf_q [0:14];
  logic        rf_we;
  logic [3:0]  rf_wa;
  logic [31:0] rf_wd;

  generate
    for (genvar gi = 0; gi < 15; gi++) begin : gen_rf
      logic [31:0] r_reg;
      always_ff @(posedge clk) begin
        if (reset)
          r_reg <= 32'd0;
        else if (rf_we && rf_wa == 4'(gi))
          r_reg <= rf_wd;
      end
      assign rf_q[gi] = r_reg;
    end
  endgenerate

  logic [3:0]  ra2;
  logic [31:0] rd1, rd2;
  assign ra2 = (op == 2'b01) ? rd : rm;
  assign rd1 = (rn == 4'd15) ? pc_plus4 : rf_q[rn];
  assign rd2 = (ra2 == 4'd15) ? pc_plus4 : rf_q[ra2];
  assign DBtheRegVal = (DBtheReg == 4'd15) ? pc_reg : rf_q[DBtheReg];

  // Immediate forms
  logic [5:0]  rot;
  logic [31:0] imm8, rot_imm, imm12, br_off;
  assign rot     = {1'b0, ir_reg[11:8], 1'b0};
  assign imm8    = {24'd0, ir_reg[7:0]};
  assign rot_imm = (imm8 >> rot) | (imm8 << (6'd32 - rot));
  assign imm12   = {20'd0, ir_reg[11:0]};
  assign br_off  = {{6{ir_reg[23]}}, ir_reg[23:0], 2'b00};

  // DP command decode: only ADD/SUB/AND/ORR are executed
  logic       dp_ok;
  logic [1:0] dp_ctl;
  always_comb begin
    dp_ok  = 1'b1;
    dp_ctl = ALU_ADD;
    case (cmd)
      4'b0100: dp_ctl = ALU_ADD;
      4'b0010: dp_ctl = ALU_SUB;
      4'b0000: dp_ctl = ALU_AND;
      4'b1100: dp_ctl = ALU_ORR;
      default: dp_ok  = 1'b0;
    endcase
  end

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cy;
      4'h3: return !cy;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cy && !z;
      4'h9: return !cy || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Shared ALU
  logic [31:0] alu_a, alu_b, alu_bx, alu_y;
  logic [1:0]  alu_ctl;
  logic [32:0] alu_sum;
  logic        alu_arith;
  logic [3:0]  alu_flags;
  always_comb begin
    alu_arith = (alu_ctl == ALU_ADD) || (alu_ctl == ALU_SUB);
    alu_bx    = (alu_ctl == ALU_SUB) ? ~alu_b : alu_b;
    alu_sum   = {1'b0, alu_a} + {1'b0, alu_bx} + {32'd0, (alu_ctl == ALU_SUB)};
    case (alu_ctl)
      ALU_AND: alu_y = alu_a & alu_b;
      ALU_ORR: alu_y = alu_a | alu_b;
      default: alu_y = alu_sum[31:0];
    endcase
    alu_flags = {alu_y[31], (alu_y == 32'd0), alu_arith & alu_sum[32],
                 alu_arith & ~(alu_a[31] ^ alu_bx[31]) & (alu_a[31] ^ alu_sum[31])};
  end

  // Control FSM: next state and datapath controls
  logic        ir_load, pc_load, ab_load, aluout_load, flags_load, data_load;
  logic        adr_sel_alu, we, done;
  logic [31:0] pc_next;
  always_comb begin
    state_next  = state_reg;
    ir_load     = 1'b0;
    pc_load     = 1'b0;
    pc_next     = pc_plus4;
    ab_load     = 1'b0;
    aluout_load = 1'b0;
    flags_load  = 1'b0;
    data_load   = 1'b0;
    rf_we       = 1'b0;
    rf_wa       = rd;
    rf_wd       = aluout_reg;
    alu_a       = a_reg;
    alu_b       = wd_reg;
    alu_ctl     = ALU_ADD;
    adr_sel_alu = 1'b0;
    we          = 1'b0;
    done        = 1'b0;
    case (state_reg)
      S_FETCH: begin
        ir_load    = 1'b1;
        pc_load    = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        ab_load = 1'b1;
        if (!cond_pass(cond, nzcv_reg)) begin
          done       = 1'b1;
          state_next = S_FETCH;
        end else begin
          case (op)
            2'b01: state_next = S_MEMADR;
            2'b00: begin
              if (!dp_ok) begin
                done       = 1'b1;
                state_next = S_FETCH;
              end else begin
                state_next = ibit ? S_EXECUTEI : S_EXECUTER;
              end
            end
            2'b10: state_next = S_BRANCH;
            default: begin
              done       = 1'b1;
              state_next = S_FETCH;
            end
          endcase
        end
      end
      S_MEMADR: begin
        alu_b       = imm12;
        alu_ctl     = ubit ? ALU_ADD : ALU_SUB;
        aluout_load = 1'b1;
        state_next  = lbit ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adr_sel_alu = 1'b1;
        data_load   = 1'b1;
        state_next  = S_MEMWB;
      end
      S_MEMWB: begin
        done = 1'b1;
        if (rd == 4'd15) begin
          pc_load = 1'b1;
          pc_next = data_reg;
        end else begin
          rf_we = 1'b1;
          rf_wd = data_reg;
        end
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_sel_alu = 1'b1;
        we          = 1'b1;
        done        = 1'b1;
        state_next  = S_FETCH;
      end
      S_EXECUTER, S_EXECUTEI: begin
        alu_b       = (state_reg == S_EXECUTEI) ? rot_imm : wd_reg;
        alu_ctl     = dp_ctl;
        aluout_load = 1'b1;
        flags_load  = sbit;
        state_next  = S_ALUWB;
      end
      S_ALUWB: begin
        done = 1'b1;
        if (rd == 4'd15) begin
          pc_load = 1'b1;
          pc_next = aluout_reg;
        end else begin
          rf_we = 1'b1;
        end
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_a   = pc_plus4;
        alu_b   = br_off;
        pc_load = 1'b1;
        pc_next = alu_y;
        // pc_reg already holds the instruction address + 4: the link value
        if (ENABLE_BL != 0 && link) begin
          rf_we = 1'b1;
          rf_wa = 4'd14;
          rf_wd = pc_reg;
        end
        done       = 1'b1;
        state_next = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_FETCH;
      pc_reg     <= RESET_PC;
      ir_reg     <= 32'd0;
      nzcv_reg   <= 4'd0;
      a_reg      <= 32'd0;
      wd_reg     <= 32'd0;
      aluout_reg <= 32'd0;
      data_reg   <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (ir_load)     ir_reg     <= MemRD;
      if (pc_load)     pc_reg     <= pc_next;
      if (ab_load)     a_reg      <= rd1;
      if (ab_load)     wd_reg     <= rd2;
      if (aluout_load) aluout_reg <= alu_y;
      if (flags_load)  nzcv_reg   <= alu_flags;
      if (data_load)   data_reg   <= MemRD;
    end
  end

  // Strobes are masked while reset is held so an abandoned store never writes
  assign MemAdr    = adr_sel_alu ? aluout_reg : pc_reg;
  assign MemWD     = wd_reg;
  assign MemWE     = we & ~reset;
  assign InstrDone = done & ~reset;
  assign DBstate   = STATE_W'(state_reg);

endmodule

// File: tb/tb_multicycle_processor.sv
// Directed program bench: two cores (BL enabled / disabled) run the same program from
// private unified memories; retire latency and architectural results are checked.
module tb_multicycle_processor;

  localparam logic [3:0] ST_FETCH    = 4'd0;
  localparam logic [3:0] ST_MEMWRITE = 4'd5;

  logic        clk = 1'b0;
  logic        reset;
  logic        init_en;
  logic [3:0]  dbreg;

  logic [31:0] memrd0, memadr0, memwd0, regval0;
  logic        memwe0, done0;
  logic [3:0]  dbstate0;
  logic [31:0] memrd1, memadr1, memwd1, regval1;
  logic        memwe1, done1;
  logic [3:0]  dbstate1;

  logic [31:0] mem0 [0:255];
  logic [31:0] mem1 [0:255];
  int          we_count0 = 0;
  int          n_compared = 0;
  int          n_mismatched = 0;

  always #5 clk = ~clk;

  multicycle_processor #(.RESET_PC(32'h0), .ENABLE_BL(1), .STATE_W(4)) dut0 (
    .clk(clk), .reset(reset), .MemRD(memrd0), .MemAdr(memadr0), .MemWD(memwd0),
    .MemWE(memwe0), .InstrDone(done0), .DBstate(dbstate0), .DBtheReg(dbreg),
    .DBtheRegVal(regval0));

  multicycle_processor #(.RESET_PC(32'h0), .ENABLE_BL(0), .STATE_W(4)) dut1 (
    .clk(clk), .reset(reset), .MemRD(memrd1), .MemAdr(memadr1), .MemWD(memwd1),
    .MemWE(memwe1), .InstrDone(done1), .DBstate(dbstate1), .DBtheReg(dbreg),
    .DBtheRegVal(regval1));

  function automatic logic [31:0] prog_word(input int i);
    case (i)
      0:  return 32'hE04F000F; // SUB  R0,R15,R15
      1:  return 32'hE2802005; // ADD  R2,R0,#5
      2:  return 32'hE3823008; // ORR  R3,R2,#8
      3:  return 32'hE5803064; // STR  R3,[R0,#100]
      4:  return 32'hE5904064; // LDR  R4,[R0,#100]
      5:  return 32'hE0525002; // SUBS R5,R2,R2
      6:  return 32'h12806001; // ADDNE R6,R0,#1
      7:  return 32'hEC000000; // op=11 word
      8:  return 32'h02807001; // ADDEQ R7,R0,#1
      9:  return 32'hEA000005; // B    0x40
      16: return 32'hEB000002; // BL   0x50
      20: return 32'hE5139001; // LDR  R9,[R3,#-1]
      21: return 32'hE28F8000; // ADD  R8,R15,#0
      22: return 32'hE28FF008; // ADD  R15,R15,#8
      26: return 32'hEAFFFFFE; // B    .
      default: return 32'h0;
    endcase
  endfunction

  assign memrd0 = mem0[memadr0[9:2]];
  assign memrd1 = mem1[memadr1[9:2]];

  always @(posedge clk) begin
    if (init_en) begin
      for (int i = 0; i < 256; i++) begin
        mem0[i] <= prog_word(i);
        mem1[i] <= prog_word(i);
      end
    end else begin
      if (memwe0) mem0[memadr0[9:2]] <= memwd0;
      if (memwe1) mem1[memadr1[9:2]] <= memwd1;
      if (memwe0) we_count0 <= we_count0 + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic get_reg(input logic [3:0] r, output logic [31:0] v0, output logic [31:0] v1);
    dbreg = r;
    #1;
    v0 = regval0;
    v1 = regval1;
  endtask

  task automatic check_reg(input string tag, input logic [3:0] r, input logic [31:0] exp);
    logic [31:0] v0, v1;
    get_reg(r, v0, v1);
    check(tag, v0, exp);
  endtask

  // Waits in the current instruction until its retire cycle; leaves time there
  task automatic wait_done(input string tag, input int exp_cycles);
    int n;
    n = 1;
    while (!done0 && n < 20) begin
      step();
      n++;
    end
    check(tag, 32'(n), 32'(exp_cycles));
  endtask

  task automatic run_instr(input string tag, input int exp_cycles);
    wait_done(tag, exp_cycles);
    step();
  endtask

  initial begin
    logic [31:0] v0, v1;
    int n;
    int we_before;
    reset   = 1'b1;
    init_en = 1'b1;
    dbreg   = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    init_en = 1'b0;
    reset   = 1'b0;

    check("reset_state", 32'(dbstate0), 32'(ST_FETCH));
    check("reset_done", 32'(done0), 32'd0);
    check_reg("reset_pc", 4'd15, 32'h0);

    // Abandon a store while it is in MEMWRITE
    n = 0;
    while (dbstate0 != ST_MEMWRITE && n < 40) begin
      step();
      n++;
    end
    check("reach_memwrite", 32'(dbstate0), 32'(ST_MEMWRITE));
    check("memwe_before_reset", 32'(memwe0), 32'd1);
    reset = 1'b1;
    #1;
    check("memwe_in_reset", 32'(memwe0), 32'd0);
    step();
    step();
    reset = 1'b0;
    check("abandoned_we_count", 32'(we_count0), 32'd0);
    check("abandoned_mem100", mem0[25], 32'h0);
    check("rst2_state", 32'(dbstate0), 32'(ST_FETCH));
    check_reg("rst2_pc", 4'd15, 32'h0);
    check_reg("rst2_r3", 4'd3, 32'h0);

    // ALU sequence
    run_instr("sub_r0_cycles", 4);
    check_reg("sub_r0", 4'd0, 32'h0);
    run_instr("add_r2_cycles", 4);
    check_reg("add_r2", 4'd2, 32'd5);
    run_instr("orr_r3_cycles", 4);
    check_reg("orr_r3", 4'd3, 32'd13);

    // Store then load
    we_before = we_count0;
    wait_done("str_cycles", 4);
    check("str_memwe", 32'(memwe0), 32'd1);
    check("str_memadr", memadr0, 32'd100);
    check("str_memwd", memwd0, 32'd13);
    step();
    check("str_we_pulses", 32'(we_count0 - we_before), 32'd1);
    check("str_mem100", mem0[25], 32'd13);
    run_instr("ldr_r4_cycles", 5);
    check_reg("ldr_r4", 4'd4, 32'd13);

    // Flags and conditions
    run_instr("subs_r5_cycles", 4);
    check_reg("subs_r5", 4'd5, 32'd0);
    run_instr("addne_cycles", 2);
    check_reg("addne_r6", 4'd6, 32'd0);
    we_before = we_count0;
    run_instr("nop_cycles", 2);
    check_reg("nop_pc", 4'd15, 32'h20);
    check("nop_no_write", 32'(we_count0 - we_before), 32'd0);
    run_instr("addeq_cycles", 4);
    check_reg("addeq_r7", 4'd7, 32'd1);

    // Branches
    run_instr("b_cycles", 3);
    check_reg("b_pc", 4'd15, 32'h40);
    run_instr("bl_cycles", 3);
    get_reg(4'd15, v0, v1);
    check("bl_pc_bl1", v0, 32'h50);
    check("bl_pc_bl0", v1, 32'h50);
    get_reg(4'd14, v0, v1);
    check("bl_r14_bl1", v0, 32'h44);
    check("bl_r14_bl0", v1, 32'h0);

    // Load with subtracted offset, R15 operand, PC as destination
    run_instr("ldr_r9_cycles", 5);
    check_reg("ldr_r9_down", 4'd9, 32'hE5803064);
    run_instr("add_r8_cycles", 4);
    check_reg("add_r8_r15", 4'd8, 32'h5C);
    run_instr("add_pc_cycles", 4);
    check_reg("add_pc", 4'd15, 32'h68);
    run_instr("b_self_cycles", 3);
    check_reg("b_self_pc", 4'd15, 32'h68);
    get_reg(4'd4, v0, v1);
    check("bl0_core_r4", v1, 32'd13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
